// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants and types for the memory bus controller: FSM encoding,
// default serial register addresses, enable and read/write encodings.
package mem_bus_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RAM_ACC = 2'd1;
    localparam logic [1:0] ST_SER_ACC = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [15:0] SER_IO_ADDR_DEF   = 16'hBF00;
    localparam logic [15:0] SER_STAT_ADDR_DEF = 16'hBF01;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between requesters/devices and the controller: fetch port,
// data port, stall, RAM side and serial side.
interface mem_bus_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;

    logic              stallreq_o;

    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    logic              ser_ce_o;
    logic              ser_we_o;
    logic [DATA_W-1:0] ser_wdata_o;
    logic [DATA_W-1:0] ser_rdata_i;
    logic              ser_send_done_i;
    logic              ser_recv_done_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  ram_rdata_i, ser_rdata_i, ser_send_done_i, ser_recv_done_i,
        output if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ser_ce_o, ser_we_o, ser_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output ram_rdata_i, ser_rdata_i, ser_send_done_i, ser_recv_done_i,
        input  if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ser_ce_o, ser_we_o, ser_wdata_o
    );

endinterface

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Counts cycles spent in a RAM access; last flags the final cycle of the
// RAM_WAIT+1 cycle window.
module mem_bus_ctrl_wait_counter
    import mem_bus_ctrl_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last
);

    logic [WAIT_CNT_W-1:0] count;

    assign last = (count == WAIT_CNT_W'(RAM_WAIT));

    // Held at zero outside an access so every access starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (!last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-port (fetch/data) arbiter that sequences single accesses to a
// wait-stated RAM or a memory-mapped serial device.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 16,
    parameter int                RAM_WAIT      = 1,
    parameter logic [ADDR_W-1:0] SER_IO_ADDR   = ADDR_W'(SER_IO_ADDR_DEF),
    parameter logic [ADDR_W-1:0] SER_STAT_ADDR = ADDR_W'(SER_STAT_ADDR_DEF)
) (
    input logic           clk,
    input logic           rst,
    mem_bus_ctrl_if.slave bus
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    port_e             port_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;

    port_e             grant;
    logic              any_req;
    logic [ADDR_W-1:0] addr_in;
    logic              we_in;
    logic              cur_we;
    logic              wait_last;
    logic              ram_ce;
    logic              ser_ce;
    logic              load;
    port_e             load_port;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] status;

    // Data port has fixed priority over instruction fetch.
    assign grant   = bus.mem_req_i ? PORT_MEM : PORT_IF;
    assign any_req = bus.mem_req_i | bus.if_req_i;
    assign addr_in = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
    assign we_in   = bus.mem_req_i ? bus.mem_we_i : MEM_READ;
    assign cur_we  = (state == ST_IDLE) ? we_in : we_q;
    assign status  = DATA_W'({bus.ser_recv_done_i, bus.ser_send_done_i});

    assign ram_ce = (state == ST_RAM_ACC);
    // A serial write parks with ser_ce low until the transmitter is free.
    assign ser_ce = (state == ST_SER_ACC) && ((we_q == MEM_READ) || bus.ser_send_done_i);

    mem_bus_ctrl_wait_counter #(
        .RAM_WAIT(RAM_WAIT)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .en  (ram_ce),
        .last(wait_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (addr_in == SER_STAT_ADDR)    state_nxt = ST_DONE;
                    else if (addr_in == SER_IO_ADDR) state_nxt = ST_SER_ACC;
                    else                             state_nxt = ST_RAM_ACC;
                end
            end
            ST_RAM_ACC: if (wait_last) state_nxt = ST_DONE;
            ST_SER_ACC: if (ser_ce) state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // The port's read data register is loaded on the edge that enters DONE.
    always_comb begin
        load      = (state_nxt == ST_DONE) && (state != ST_DONE);
        load_port = (state == ST_IDLE) ? grant : port_q;
        case (state)
            ST_RAM_ACC: cap = bus.ram_rdata_i;
            ST_SER_ACC: cap = bus.ser_rdata_i;
            default:    cap = status;
        endcase
        load_data = (cur_we == MEM_WRITE) ? '0 : cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            port_q      <= PORT_IF;
            addr_q      <= '0;
            we_q        <= MEM_READ;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && any_req) begin
                port_q  <= grant;
                addr_q  <= addr_in;
                we_q    <= we_in;
                wdata_q <= (we_in == MEM_WRITE) ? bus.mem_wdata_i : '0;
            end
            if (load) begin
                if (load_port == PORT_MEM) mem_rdata_q <= load_data;
                else                       if_rdata_q  <= load_data;
            end
        end
    end

    assign bus.ram_ce_o    = ram_ce;
    assign bus.ram_we_o    = ram_ce & we_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_wdata_o = (ram_ce && (we_q == MEM_WRITE)) ? wdata_q : '0;

    assign bus.ser_ce_o    = ser_ce;
    assign bus.ser_we_o    = ser_ce & we_q;
    assign bus.ser_wdata_o = wdata_q;

    assign bus.if_ready_o  = (state == ST_DONE) && (port_q == PORT_IF);
    assign bus.mem_ready_o = (state == ST_DONE) && (port_q == PORT_MEM);
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.mem_rdata_o = mem_rdata_q;

    assign bus.stallreq_o  = (bus.if_req_i  & ~bus.if_ready_o)
                           | (bus.mem_req_i & ~bus.mem_ready_o);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed scenarios plus randomized
// single transactions against a queue/array reference model.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int          DW   = 16;
    localparam int          AW   = 16;
    localparam int          RW   = 1;
    localparam logic [15:0] IO_A = 16'hBF00;
    localparam logic [15:0] ST_A = 16'hBF01;

    typedef struct {
        logic        port;   // 1 = mem, 0 = if
        logic [15:0] rdata;
        int          issue;
        int          lat;    // -1 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_bus_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .RAM_WAIT(RW),
        .SER_IO_ADDR(IO_A), .SER_STAT_ADDR(ST_A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    logic [15:0] ser_wq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ce_run   = 0;
    logic [15:0] ref_mem[256];
    logic [15:0] ram_arr[256];
    logic        ram_inited = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // RAM device: combinational read, write on edges where ce&we are high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && !ram_inited) begin
            for (int i = 0; i < 256; i++) ram_arr[i] <= 16'(i * 37 + 16'h1200);
            ram_inited <= 1'b1;
        end else if (bus.ram_ce_o && bus.ram_we_o) begin
            ram_arr[bus.ram_addr_o[7:0]] <= bus.ram_wdata_o;
        end
    end
    assign bus.ram_rdata_i = ram_arr[bus.ram_addr_o[7:0]];

    // Monitor: pops the scoreboard on every ready and checks bus invariants.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ce_run = 0;
        end else begin
            if (bus.mem_ready_o || bus.if_ready_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'({bus.if_ready_o, bus.mem_ready_o}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_port", 32'({bus.if_ready_o, bus.mem_ready_o}),
                        e.port ? 32'd1 : 32'd2);
                    chk(e.port ? "mem_rdata" : "if_rdata",
                        32'(e.port ? bus.mem_rdata_o : bus.if_rdata_o), 32'(e.rdata));
                    if (e.lat >= 0) chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end
            if (bus.ram_ce_o) begin
                ce_run++;
            end else if (ce_run != 0) begin
                chk("ram_ce_len", 32'(ce_run), 32'(RW + 1));
                ce_run = 0;
            end
            if (bus.ram_ce_o || bus.ser_ce_o)
                chk("ce_exclusive", 32'(bus.ram_ce_o & bus.ser_ce_o), 32'd0);
            if (bus.ram_ce_o && !bus.ram_we_o)
                chk("ram_wdata_read", 32'(bus.ram_wdata_o), 32'd0);
            if (bus.ser_ce_o && bus.ser_we_o) begin
                chk("ser_wr_send_done", 32'(bus.ser_send_done_i), 32'd1);
                if (ser_wq.size() == 0) chk("ser_wr_unexpected", 32'(ser_wq.size()), 32'd1);
                else chk("ser_wdata", 32'(bus.ser_wdata_o), 32'(ser_wq.pop_front()));
            end
        end
    end

    task automatic push_exp(input logic p, input logic [15:0] d, input int lat);
        exp_t e;
        e.port  = p;
        e.rdata = d;
        e.issue = cyc;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Waits for ready of one port while that port keeps requesting.
    task automatic wait_ready(input logic p, input bit ser_wr, input int hold, input bit chk_stall);
        bit got;
        logic rdy;
        got = 1'b0;
        rdy = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk); #1;
            if (ser_wr && k >= hold) bus.ser_send_done_i = 1'b1;
            #1;
            rdy = p ? bus.mem_ready_o : bus.if_ready_o;
            if (ser_wr && k < hold) chk("ser_ce_while_busy", 32'(bus.ser_ce_o), 32'd0);
            if (chk_stall) chk(rdy ? "stall_at_done" : "stall_waiting",
                               32'(bus.stallreq_o), rdy ? 32'd0 : 32'd1);
            if (rdy) got = 1'b1;
        end
        if (!got) chk("ready_timeout", 32'(rdy), 32'd1);
        @(posedge clk); #1;
        if (p) bus.mem_req_i = 1'b0;
        else   bus.if_req_i  = 1'b0;
    endtask

    task automatic do_txn(input logic p, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input int hold);
        logic [15:0] er;
        int          lat;
        bit          ser_wr;
        ser_wr = 1'b0;
        if (a == ST_A) begin
            er  = w ? 16'h0 : {14'b0, bus.ser_recv_done_i, bus.ser_send_done_i};
            lat = 1;
        end else if (a == IO_A) begin
            if (w) begin
                er     = 16'h0;
                lat    = -1;
                ser_wr = 1'b1;
                ser_wq.push_back(d);
                bus.ser_send_done_i = (hold == 0);
            end else begin
                er  = bus.ser_rdata_i;
                lat = 2;
            end
        end else begin
            lat = RW + 2;
            if (w) begin
                ref_mem[a[7:0]] = d;
                er = 16'h0;
            end else begin
                er = ref_mem[a[7:0]];
            end
        end
        if (p) begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = w;
            bus.mem_addr_i  = a;
            bus.mem_wdata_i = d;
        end else begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = a;
        end
        push_exp(p, er, lat);
        wait_ready(p, ser_wr, hold, 1'b1);
    endtask

    initial begin
        int          kind;
        logic        p;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 16'h1200);
        bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
        bus.ser_rdata_i = '0; bus.ser_send_done_i = 1'b0; bus.ser_recv_done_i = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_if_ready",  32'(bus.if_ready_o),  32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready_o), 32'd0);
        chk("rst_ram_ce",    32'(bus.ram_ce_o),    32'd0);
        chk("rst_ser_ce",    32'(bus.ser_ce_o),    32'd0);
        chk("rst_rdata",     32'({bus.if_rdata_o, bus.mem_rdata_o}), 32'd0);
        chk("rst_stall",     32'(bus.stallreq_o),  32'd0);

        // RAM write then read-back of 0x0040.
        do_txn(1'b1, 1'b1, 16'h0040, 16'h1234, 0);
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0);

        // Simultaneous fetch read and data write: data port served first.
        ref_mem[8'h10] = 16'hABCD;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 16'h0010; bus.mem_wdata_i = 16'hABCD;
        bus.if_req_i  = 1'b1; bus.if_addr_i = 16'h0000;
        push_exp(1'b1, 16'h0000, RW + 2);
        push_exp(1'b0, ref_mem[8'h00], 2 * (RW + 2) + 1);
        wait_ready(1'b1, 1'b0, 0, 1'b0);
        wait_ready(1'b0, 1'b0, 0, 1'b0);
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0, 0);

        // Serial write held off by a busy transmitter for 5 cycles.
        do_txn(1'b1, 1'b1, IO_A, 16'h0041, 5);

        // Status read/write, serial read.
        bus.ser_recv_done_i = 1'b1; bus.ser_send_done_i = 1'b0;
        do_txn(1'b1, 1'b0, ST_A, 16'h0, 0);
        bus.ser_recv_done_i = 1'b1; bus.ser_send_done_i = 1'b1;
        do_txn(1'b1, 1'b1, ST_A, 16'h5555, 0);
        bus.ser_rdata_i = 16'h00C3;
        do_txn(1'b0, 1'b0, IO_A, 16'h0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            p    = 1'($urandom_range(0, 1));
            w    = p ? 1'($urandom_range(0, 1)) : 1'b0;
            d    = 16'($urandom);
            bus.ser_recv_done_i = 1'($urandom_range(0, 1));
            bus.ser_send_done_i = 1'($urandom_range(0, 1));
            bus.ser_rdata_i     = 16'($urandom);
            if (kind < 6)      a = 16'($urandom_range(0, 32'hBEFF));
            else if (kind < 8) a = IO_A;
            else               a = ST_A;
            do_txn(p, w, a, d, int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a RAM read: access is dropped silently.
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0, 0);
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 16'h0022;
        @(posedge clk); #1;
        chk("pre_rst_ram_ce", 32'(bus.ram_ce_o), 32'd1);
        rst = 1'b1;
        bus.mem_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ram_ce",    32'(bus.ram_ce_o),    32'd0);
        chk("abort_ser_ce",    32'(bus.ser_ce_o),    32'd0);
        chk("abort_mem_ready", 32'(bus.mem_ready_o), 32'd0);
        chk("abort_mem_rdata", 32'(bus.mem_rdata_o), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0, 0);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("ser_queue_empty",  32'(ser_wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
